// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide engine.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] hi_cur;
    logic [WIDTH-1:0] lo_cur;
    logic             cancel;
    logic             busy;
    logic             hilowe;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start, op, src_a, src_b, hi_cur, lo_cur, cancel,
        input  busy, hilowe, hi_o, lo_o
    );
    modport slave (
        input  start, op, src_a, src_b, hi_cur, lo_cur, cancel,
        output busy, hilowe, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// HI/LO write-side engine: single-cycle MULT/MULTU, MTHI/MTLO, and a
// radix-2 restoring DIV/DIVU that stalls the pipeline through busy.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = WIDTH
) (
    input logic      cpu_clk_50M,
    input logic      cpu_rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(DIV_STEPS + 1);

    typedef logic [WIDTH-1:0] reg_t;
    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;

    state_t        state;
    reg_t          rem, quo, dvs;
    logic          q_neg, r_neg;
    logic [CW-1:0] cnt;
    logic          busy_r, hilowe_r;
    reg_t          hi_r, lo_r;

    // op[0] clear selects the signed flavour for both MULT and DIV
    logic               is_signed, a_neg, b_neg, step_ok;
    reg_t               abs_a, abs_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH:0]     rem_sh, diff;

    always_comb begin
        is_signed = ~bus.op[0];
        a_neg     = is_signed & bus.src_a[WIDTH-1];
        b_neg     = is_signed & bus.src_b[WIDTH-1];
        abs_a     = a_neg ? -bus.src_a : bus.src_a;
        abs_b     = b_neg ? -bus.src_b : bus.src_b;
        // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits correct for signed operands
        a_ext     = {{WIDTH{a_neg}}, bus.src_a};
        b_ext     = {{WIDTH{b_neg}}, bus.src_b};
        prod      = a_ext * b_ext;
        rem_sh    = {rem, quo[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvs};
        step_ok   = ~diff[WIDTH];
        quo_fix   = q_neg ? -quo : quo;
        rem_fix   = r_neg ? -rem : rem;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            hilowe_r <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            hilowe_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        case (bus.op)
                            3'b000, 3'b001: begin
                                hi_r     <= prod[2*WIDTH-1:WIDTH];
                                lo_r     <= prod[WIDTH-1:0];
                                hilowe_r <= 1'b1;
                            end
                            3'b010, 3'b011: begin
                                if (bus.src_b == '0) begin
                                    hi_r     <= bus.src_a;
                                    lo_r     <= '1;
                                    hilowe_r <= 1'b1;
                                end else begin
                                    rem    <= '0;
                                    quo    <= abs_a;
                                    dvs    <= abs_b;
                                    q_neg  <= a_neg ^ b_neg;
                                    r_neg  <= a_neg;
                                    cnt    <= '0;
                                    busy_r <= 1'b1;
                                    state  <= DIV_RUN;
                                end
                            end
                            3'b100: begin
                                hi_r     <= bus.src_a;
                                lo_r     <= bus.lo_cur;
                                hilowe_r <= 1'b1;
                            end
                            3'b101: begin
                                hi_r     <= bus.hi_cur;
                                lo_r     <= bus.src_a;
                                hilowe_r <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                DIV_RUN: begin
                    if (bus.cancel) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        rem <= step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], step_ok};
                        cnt <= cnt + CW'(1);
                        // busy drops as the last step lands so it covers exactly DIV_STEPS cycles
                        if (cnt == CW'(DIV_STEPS - 1)) begin
                            state  <= DIV_FIX;
                            busy_r <= 1'b0;
                        end
                    end
                end
                DIV_FIX: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    if (!bus.cancel) begin
                        hi_r     <= rem_fix;
                        lo_r     <= quo_fix;
                        hilowe_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.hilowe = hilowe_r;
    assign bus.hi_o   = hi_r;
    assign bus.lo_o   = lo_r;
endmodule
